// File: rtl/sauria_addr_router.sv
// Programmable region decoder and single-stage request router for SAURIA in Cheshire.
// Optional feature: define SAURIA_ROUTER_OFFSET_EN for region-relative forwarded addresses.
module sauria_addr_router #(
    parameter int unsigned                      NumRegions = 2,
    parameter int unsigned                      AddrWidth  = 64,
    parameter logic [NumRegions*AddrWidth-1:0] DefStart   = {64'h4500_0000, 64'h4000_0000},
    parameter logic [NumRegions*AddrWidth-1:0] DefEnd     = {64'h4F00_0000, 64'h4500_0000},
    // Derived from NumRegions; leave at its default.
    parameter int unsigned                      IdxWidth   = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 mst_valid_o,
    input  logic                 mst_ready_i,
    output logic [AddrWidth-1:0] mst_addr_o,
    output logic [IdxWidth-1:0]  mst_idx_o,
    output logic                 mst_err_o,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic                 cfg_sel_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    output logic [15:0]          err_cnt_o
);

    logic [AddrWidth-1:0] start_q [NumRegions];
    logic [AddrWidth-1:0] end_q   [NumRegions];

    logic                 mst_valid_q, mst_valid_d;
    logic [AddrWidth-1:0] mst_addr_q,  mst_addr_d;
    logic [IdxWidth-1:0]  mst_idx_q,   mst_idx_d;
    logic                 mst_err_q,   mst_err_d;
    logic                 cfg_err_q,   cfg_err_d;
    logic [15:0]          err_cnt_q,   err_cnt_d;

    logic                 hit;
    logic [IdxWidth-1:0]  hit_idx;
    logic [AddrWidth-1:0] fwd_addr;
    logic                 req_hs;
    logic                 cfg_idx_ok;

    assign req_ready_o = !mst_valid_q || mst_ready_i;
    assign req_hs      = req_valid_i && req_ready_o;
    assign cfg_idx_ok  = 32'(cfg_idx_i) < NumRegions;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NumRegions - 1; i >= 0; i--) begin
            if ((start_q[i] < end_q[i]) && (req_addr_i >= start_q[i]) && (req_addr_i < end_q[i])) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(i);
            end
        end
    end

`ifdef SAURIA_ROUTER_OFFSET_EN
    logic [AddrWidth-1:0] hit_start;

    always_comb begin
        hit_start = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (hit_idx == IdxWidth'(i)) begin
                hit_start = start_q[i];
            end
        end
    end

    assign fwd_addr = hit ? (req_addr_i - hit_start) : req_addr_i;
`else
    assign fwd_addr = req_addr_i;
`endif

    always_comb begin
        cfg_rdata_o = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (cfg_idx_i == 4'(i)) begin
                cfg_rdata_o = cfg_sel_i ? end_q[i] : start_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegions; i++) begin
                start_q[i] <= DefStart[i*AddrWidth +: AddrWidth];
                end_q[i]   <= DefEnd[i*AddrWidth +: AddrWidth];
            end
        end else if (cfg_we_i) begin
            for (int i = 0; i < NumRegions; i++) begin
                if (cfg_idx_i == 4'(i)) begin
                    if (cfg_sel_i) begin
                        end_q[i] <= cfg_wdata_i;
                    end else begin
                        start_q[i] <= cfg_wdata_i;
                    end
                end
            end
        end
    end

    // Payload only loads on an accepted request, so it holds while stalled.
    always_comb begin
        mst_valid_d = mst_valid_q;
        mst_addr_d  = mst_addr_q;
        mst_idx_d   = mst_idx_q;
        mst_err_d   = mst_err_q;
        err_cnt_d   = err_cnt_q;
        if (req_hs) begin
            mst_valid_d = 1'b1;
            mst_addr_d  = fwd_addr;
            mst_idx_d   = hit_idx;
            mst_err_d   = !hit;
            if (!hit && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end else if (mst_ready_i) begin
            mst_valid_d = 1'b0;
        end
        cfg_err_d = cfg_we_i && !cfg_idx_ok;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_valid_q <= 1'b0;
            mst_addr_q  <= '0;
            mst_idx_q   <= '0;
            mst_err_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            mst_valid_q <= mst_valid_d;
            mst_addr_q  <= mst_addr_d;
            mst_idx_q   <= mst_idx_d;
            mst_err_q   <= mst_err_d;
            cfg_err_q   <= cfg_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mst_valid_o = mst_valid_q;
    assign mst_addr_o  = mst_addr_q;
    assign mst_idx_o   = mst_idx_q;
    assign mst_err_o   = mst_err_q;
    assign cfg_err_o   = cfg_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/sauria_addr_router.md
# sauria_addr_router

Runtime-programmable address decoder and request router for SAURIA integration in Cheshire. It replaces the fixed, elaboration-time SAURIA register and memory windows with a table of `NumRegions` start/end pairs. The table resets to parameter defaults and can be rewritten through a config port. Incoming requests are matched against the table and forwarded through one registered stage, tagged with the winning region index; unmapped addresses are flagged and counted.

## Interface
- `NumRegions`, 2, number of decode regions (1..16)
- `AddrWidth`, 64, request and region address width
- `DefStart`, {0x4500_0000, 0x4000_0000}, packed array of reset start addresses, index 0 in LSBs
- `DefEnd`, {0x4F00_0000, 0x4500_0000}, packed array of reset end addresses (exclusive)
- `IdxWidth`, max(1,$clog2(NumRegions)), derived, not to be overridden
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request ready
- `req_addr_i` in AddrWidth: request address
- `mst_valid_o` out 1: forwarded request valid
- `mst_ready_i` in 1: downstream ready
- `mst_addr_o` out AddrWidth: forwarded address
- `mst_idx_o` out IdxWidth: matched region index
- `mst_err_o` out 1: forwarded request hit no region
- `cfg_we_i` in 1: table write strobe
- `cfg_idx_i` in 4: region index for read/write
- `cfg_sel_i` in 1: 0 = start, 1 = end
- `cfg_wdata_i` in AddrWidth: write data
- `cfg_rdata_o` out AddrWidth: read data, combinational
- `cfg_err_o` out 1: pulse, write to `cfg_idx_i >= NumRegions`
- `err_cnt_o` out 16: saturating count of unmapped requests

## Operation
- Region i matches when `start[i] <= addr < end[i]`, both unsigned. A region with `start >= end` is disabled and never matches.
- Overlapping regions: the lowest index wins. No match sets `mst_err_o = 1` and `mst_idx_o = 0`. An error request is still forwarded so that downstream can generate the error response.
- Output stage is a single register: `req_ready_o = !mst_valid_o || mst_ready_i`. On an input handshake, the address, index and error bit are captured and `mst_valid_o` is set. On an output handshake with no new input, `mst_valid_o` clears.
- Output stability: while `mst_valid_o && !mst_ready_i`, all `mst_*` outputs hold.
- Table write: on `cfg_we_i` with a valid index, the selected register updates at the clock edge. Decode is combinational from the current table, so a request accepted in the same cycle as a write uses the old value.
- Invalid-index write: the table is unchanged and `cfg_err_o` pulses high for one cycle, registered.
- `cfg_rdata_o` returns the selected register, or 0 for an invalid index.
- `err_cnt_o` increments on every input handshake with no match and saturates at 0xFFFF.

## Timing
- Latency: 1 cycle from input handshake to `mst_valid_o`. Full throughput of 1 request per cycle while `mst_ready_i = 1`.
- Reset values:
  - `mst_valid_o = 0`, `mst_addr_o = 0`, `mst_idx_o = 0`, `mst_err_o = 0`
  - `cfg_err_o = 0`, `err_cnt_o = 0`
  - table = `DefStart`/`DefEnd`
  - `req_ready_o = 1`
- Reset mid-operation: any in-flight request is dropped and no replay occurs. Table edits are lost.
- No combinational path from `req_valid_i` to `req_ready_o`. `mst_ready_i` to `req_ready_o` is combinational.

## Configuration
- `SAURIA_ROUTER_OFFSET_EN` defined: `mst_addr_o = addr - start[idx]` on a match, i.e. region-relative addressing for SAURIA slaves. Error requests pass the address unchanged.
- Undefined: `mst_addr_o` is always the unmodified request address.

## Test plan
- Reset defaults: request 0x4000_0010 -> `mst_idx_o = 0`, `mst_err_o = 0`. Request 0x4500_0000 -> idx 1. Request 0x4F00_0000 -> `mst_err_o = 1`, `err_cnt_o = 1`. With `_EN`, the first two give `mst_addr_o` 0x10 and 0x0.
- Backpressure: hold `mst_ready_i = 0` with `req_valid_i = 1` for 5 cycles -> one request captured, `req_ready_o = 0`, outputs stable. Release -> back-to-back streaming of 1 per cycle with no loss or duplication.
- Reprogram: write region 1 end = 0x5000_0000 -> 0x4F00_0000 hits idx 1. Same-cycle write plus request uses the old end and reports an error.
- Overlap/disable: set region 1 = [0x4000_0000, 0x5000_0000) -> 0x4100_0000 goes to idx 0. Set region 0 start = end -> it goes to idx 1.
- Invalid config: write `cfg_idx_i = 3` with NumRegions = 2 -> `cfg_err_o` pulses once, table unchanged, `cfg_rdata_o = 0` for idx 3.
- Saturation and reset: force 65 540 unmapped requests -> `err_cnt_o = 0xFFFF`. Assert `rst_ni` low mid-stream -> all outputs return to reset values asynchronously and the table returns to its defaults.
